// File: rtl/core_ifetch_if.sv
// Fetch-stage bundle: redirect request, OCM instruction port and decode handshake.
// master = fetch unit, slave = surrounding core / memory.
interface core_ifetch_if;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        insn_reset;
   logic        insn_request;
   logic [15:0] insn_addr;
   logic        insn_valid;
   logic [31:0] insn_data;
   logic        if_valid;
   logic [15:0] if_pc;
   logic [31:0] if_insn;
   logic        if_ready;

   modport master (
      input  redirect, redirect_pc, insn_valid, insn_data, if_ready,
      output insn_reset, insn_request, insn_addr, if_valid, if_pc, if_insn
   );

   modport slave (
      output redirect, redirect_pc, insn_valid, insn_data, if_ready,
      input  insn_reset, insn_request, insn_addr, if_valid, if_pc, if_insn
   );
endinterface

// File: rtl/core_ifetch.sv
// Instruction fetch: one OCM read per cycle, credit-limited by a small FIFO toward decode.
// Redirects flush the FIFO and the in-flight read, and pulse insn_reset for one cycle.
module core_ifetch #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   core_ifetch_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] insn;
   } fq_entry_t;

   fq_entry_t         fifo_mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_pop;
   logic [CW:0]       credit;
   logic              pending, rst_pulse;
   logic [15:0]       pend_pc, fetch_pc;
   logic              pop, push, drop, issue;

   // Redirect overrides everything: no pop, no capture, no issue in that cycle.
   always_comb begin
      pop       = (count != '0) && bus.if_ready && !bus.redirect;
      push      = pending && bus.insn_valid && !bus.redirect;
      drop      = pending && !bus.insn_valid;
      count_pop = count - CW'(pop);
      credit    = {1'b0, count_pop} + (CW+1)'(pending);
      issue     = !rst_pulse && !bus.redirect && !drop && (credit < DEPTH_C);
   end

   assign bus.insn_reset   = rst_pulse;
   assign bus.insn_request = issue;
   assign bus.insn_addr    = fetch_pc;
   assign bus.if_valid     = (count != '0);
   assign bus.if_pc        = bus.if_valid ? fifo_mem[rd_ptr].pc   : 16'h0000;
   assign bus.if_insn      = bus.if_valid ? fifo_mem[rd_ptr].insn : 32'h0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rst_pulse <= 1'b1;
         pending   <= 1'b0;
         pend_pc   <= RESET_PC;
         fetch_pc  <= RESET_PC;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         rst_pulse <= bus.redirect;
         pending   <= issue;
         if (issue)
            pend_pc <= fetch_pc;

         // A dropped response rewinds fetch to the word that was lost.
         if (bus.redirect)
            fetch_pc <= {bus.redirect_pc[15:2], 2'b00};
         else if (drop)
            fetch_pc <= pend_pc;
         else if (issue)
            fetch_pc <= fetch_pc + 16'd4;

         if (bus.redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_pop + CW'(push);
         end
      end
   end

   // Payload storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge sys_clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{pc: pend_pc, insn: bus.insn_data};
   end
endmodule

// File: doc/core_ifetch.md
Name: core_ifetch

Overview:
Instruction fetch stage upstream of the on-chip memory instruction port. It holds the fetch PC and issues one 32-bit instruction read per cycle to the OCM insn path. Returned words go into a small FIFO that feeds decode through a valid/ready handshake. Branch redirects flush the FIFO and in-flight reads, and pulse the OCM insn_reset.

Parameters:
DEPTH, 4, instruction FIFO entries; power of 2, minimum 2
RESET_PC, 16'h0000, fetch PC loaded at reset; bits [1:0] must be 0

Ports:
sys_clk  input  1  clock
sys_rst  input  1  asynchronous active-high reset
redirect  input  1  one-cycle request to restart fetch at redirect_pc
redirect_pc  input  16  new fetch address; bits [1:0] ignored and treated as 0
insn_reset  output  1  to OCM; clears OCM insn_valid
insn_request  output  1  to OCM; read strobe
insn_addr  output  16  to OCM; byte address of word, bits [1:0]=0
insn_valid  input  1  from OCM; response qualifier
insn_data  input  32  from OCM; word for the previous cycle's request
if_valid  output  1  FIFO head valid toward decode
if_pc  output  16  PC of head word
if_insn  output  32  head instruction word
if_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset values: insn_reset=1 while sys_rst is high and for the first cycle after release, then 0. insn_request=0, insn_addr=RESET_PC, if_valid=0, if_pc=0, if_insn=0. FIFO is empty, pending=0, fetch PC=RESET_PC.
- OCM contract: a request in cycle N returns insn_data in cycle N+1. Capture the word when pending && insn_valid.
- pending is a registered copy of insn_request. It holds the PC of the in-flight word.
- Issue rule: insn_request=1 iff !insn_reset && !redirect && (count + pending) < DEPTH.
  - count is the FIFO occupancy after this cycle's pop.
  - This is credit-based: a returned word never finds the FIFO full.
- insn_addr equals the fetch PC combinationally.
- On issue, fetch PC <= PC+4, wrapping modulo 2^16. 16'hFFFC is followed by 16'h0000.
- FIFO push: the captured word plus its PC, in the cycle of return.
- FIFO pop: if_valid && if_ready.
- Push and pop in the same cycle is allowed, and count is unchanged.
- Zero bypass: a returned word is visible on if_valid no earlier than the cycle after capture.
  - Minimum latency is request to if_valid = 2 cycles.
- if_valid = count != 0. if_pc and if_insn are driven from the head entry, registered storage.
- Redirect in cycle R:
  - No request is issued in R.
  - At the edge ending R:
    - FIFO is emptied.
    - pending is cleared, so a word returning in R+1 is discarded.
    - fetch PC <= {redirect_pc[15:2],2'b00}.
    - insn_reset <= 1 for exactly cycle R+1.
  - No request is issued in R+1. The first new request is in R+2.
  - A pop in R is ignored; if_ready in R has no effect.
- Back-to-back redirects: the last one wins. Each extends the insn_reset pulse by one cycle.
- Redirect has priority over push, pop and issue in the same cycle.
- insn_valid low while pending=1 (not expected after reset pulse): word dropped and the fetch PC is rolled back to that word's PC. A request in that cycle is suppressed.
- Async reset mid-operation: all state returns to reset values immediately and any in-flight response is discarded.

Test Plan:
- Reset release, if_ready=1, memory returns addr-as-data:
  - insn_reset high for the first cycle after release.
  - Requests start at 16'h0000.
  - if_valid first rises 2 cycles after the first request.
  - if_pc sequence is 0,4,8,… one per cycle, with if_insn matching.
- if_ready=0 for 10 cycles:
  - Exactly DEPTH=4 words are buffered (PCs 0,4,8,C).
  - insn_request stays low.
  - Raising if_ready drains 0,4,8,C in order with no gap.
- Redirect to 16'h1232 while the FIFO is full and a request is in flight:
  - FIFO empty and if_valid=0 next cycle.
  - insn_reset pulses for 1 cycle.
  - The next request is at 16'h1230.
  - The stale response is never delivered.
- PC wrap: redirect to 16'hFFF8 with if_ready=1:
  - Delivered PCs are FFF8, FFFC, 0000, 0004.
- Redirect on two consecutive cycles (16'h0100 then 16'h0200):
  - insn_reset high for 2 cycles.
  - Fetch resumes at 16'h0200 only; no 16'h0100 word is delivered.
- Random if_ready toggling for 1000 cycles with random redirects:
  - Scoreboard sees in-order PCs with no drops or duplicates between redirects.
  - The FIFO never overflows.
  - count+pending never exceeds DEPTH.
